// File: rtl/nphy_toggle_pkg.sv
// Shared types, constants and helpers for the Toggle NAND
// command/address sequencer.
package nphy_toggle_pkg;

   localparam int NUMBER_OF_WAYS = 4;
   localparam int WAY_W = $clog2(NUMBER_OF_WAYS);
   localparam int MAX_ADDR_BYTES = 5;

   localparam logic [3:0] PH_ON  = 4'b1111;
   localparam logic [3:0] PH_OFF = 4'b0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WE_ON,
      ST_HOLD,
      ST_WB_WAIT,
      ST_RB_POLL,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [7:0]  cmd0;
      logic [2:0]  n_addr;
      logic [39:0] addr;
      logic        has_cmd1;
      logic [7:0]  cmd1;
      logic        wait_rb;
   } req_t;

   typedef struct packed {
      logic       is_cmd;
      logic [7:0] data;
   } tx_byte_t;

   function automatic logic [23:0] sat_inc(input logic [23:0] c);
      return (c == 24'hFF_FFFF) ? c : c + 24'd1;
   endfunction

   function automatic logic [2:0] last_index(input req_t r);
      return r.n_addr + {2'b00, r.has_cmd1};
   endfunction

   // Byte list: CMD0, then address bytes, then CMD1.
   function automatic tx_byte_t pick_byte(input req_t r,
                                          input logic [2:0] idx);
      tx_byte_t b;
      if (idx == 3'd0) begin
         b = '{is_cmd: 1'b1, data: r.cmd0};
      end else if (idx <= r.n_addr) begin
         b = '{is_cmd: 1'b0,
               data: r.addr[8*(int'(idx)-1) +: 8]};
      end else begin
         b = '{is_cmd: 1'b1, data: r.cmd1};
      end
      return b;
   endfunction

endpackage

// File: rtl/nphy_toggle_rb_waiter.sv
// Write-to-busy delay followed by ready/busy polling with a
// saturating timeout counter.
module nphy_toggle_rb_waiter
   import nphy_toggle_pkg::*;
#(
   parameter int WBWaitCycles    = 10,
   parameter int RBTimeoutCycles = 1 << 20
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic ready_busy,
   output logic done,
   output logic timeout
);

   localparam logic [23:0] WB_LAST =
      24'((WBWaitCycles > 0) ? WBWaitCycles - 1 : 0);
   localparam logic [23:0] TO_LAST =
      24'((RBTimeoutCycles > 0) ? RBTimeoutCycles - 1 : 0);

   state_t      state;
   logic [23:0] cnt;

   assign done    = (state == ST_RB_POLL) &&
                    (ready_busy || cnt >= TO_LAST);
   assign timeout = done && !ready_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= (WBWaitCycles > 0) ? ST_WB_WAIT
                                              : ST_RB_POLL;
                  cnt   <= '0;
               end
            end
            ST_WB_WAIT: begin
               if (cnt == WB_LAST) begin
                  state <= ST_RB_POLL;
                  cnt   <= '0;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            ST_RB_POLL: begin
               if (done) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/nphy_toggle_cmd_sequencer.sv
// Toggle NAND command/address sequencer: strobes CMD0, address
// bytes and CMD1 onto the PO lanes, then optionally waits on R/B.
module nphy_toggle_cmd_sequencer
   import nphy_toggle_pkg::*;
#(
   parameter int NumberOfWays    = 4,
   parameter int SetupCycles     = 1,
   parameter int WEPulseCycles   = 2,
   parameter int HoldCycles      = 1,
   parameter int WBWaitCycles    = 10,
   parameter int RBTimeoutCycles = 1 << 20
) (
   input  logic                          iSystemClock,
   input  logic                          iReset,
   input  logic                          iReqValid,
   output logic                          oReqReady,
   input  logic [$clog2(NumberOfWays)-1:0] iReqWay,
   input  logic [7:0]                    iReqCmd0,
   input  logic [2:0]                    iReqAddrCount,
   input  logic [39:0]                   iReqAddr,
   input  logic                          iReqHasCmd1,
   input  logic [7:0]                    iReqCmd1,
   input  logic                          iReqWaitRB,
   input  logic [NumberOfWays-1:0]       iReadyBusy,
   output logic                          oDone,
   output logic                          oTimeout,
   output logic                          oDQOutEnable,
   output logic [31:0]                   oPO_DQ,
   output logic [2*NumberOfWays-1:0]     oPO_ChipEnable,
   output logic [3:0]                    oPO_WriteEnable,
   output logic [3:0]                    oPO_AddressLatchEnable,
   output logic [3:0]                    oPO_CommandLatchEnable,
   output logic [3:0]                    oPO_ReadEnable
);

   localparam int WayW = $clog2(NumberOfWays);
   localparam logic [23:0] SU_LAST = 24'(SetupCycles - 1);
   localparam logic [23:0] WE_LAST = 24'(WEPulseCycles - 1);
   localparam logic [23:0] HO_LAST = 24'(HoldCycles - 1);

   state_t      state, nxt;
   logic [23:0] cnt, nxt_cnt;
   logic [2:0]  idx, nxt_idx;
   req_t        req_q, req_in, req_d;
   logic [WayW-1:0] way_q, way_d;
   tx_byte_t    sel;
   logic        accept, strobe;
   logic        rb_start, rb_done, rb_timeout;
   logic [2*NumberOfWays-1:0] ce_d;

   assign oPO_ReadEnable = PH_OFF;

   assign req_in = '{
      cmd0:     iReqCmd0,
      n_addr:   (iReqAddrCount > 3'(MAX_ADDR_BYTES))
                ? 3'(MAX_ADDR_BYTES) : iReqAddrCount,
      addr:     iReqAddr,
      has_cmd1: iReqHasCmd1,
      cmd1:     iReqCmd1,
      wait_rb:  iReqWaitRB
   };

   // Outputs are registered from the next state, so the fields of a
   // request being accepted are used directly on the accept edge.
   always_comb begin
      accept   = iReqValid && oReqReady;
      req_d    = accept ? req_in : req_q;
      way_d    = accept ? iReqWay : way_q;
      nxt      = state;
      nxt_idx  = idx;
      nxt_cnt  = sat_inc(cnt);
      rb_start = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               nxt     = ST_SETUP;
               nxt_idx = '0;
               nxt_cnt = '0;
            end
         end
         ST_SETUP: begin
            if (cnt == SU_LAST) begin
               nxt     = ST_WE_ON;
               nxt_cnt = '0;
            end
         end
         ST_WE_ON: begin
            if (cnt == WE_LAST) begin
               nxt     = ST_HOLD;
               nxt_cnt = '0;
            end
         end
         ST_HOLD: begin
            if (cnt == HO_LAST) begin
               nxt_cnt = '0;
               if (idx != last_index(req_q)) begin
                  nxt     = ST_SETUP;
                  nxt_idx = idx + 3'd1;
               end else if (req_q.wait_rb) begin
                  nxt      = ST_WB_WAIT;
                  rb_start = 1'b1;
               end else begin
                  nxt = ST_DONE;
               end
            end
         end
         ST_WB_WAIT, ST_RB_POLL: begin
            if (rb_done) nxt = ST_DONE;
         end
         default: nxt = ST_IDLE;
      endcase
      sel    = pick_byte(req_d, nxt_idx);
      strobe = (nxt == ST_SETUP) || (nxt == ST_WE_ON) ||
               (nxt == ST_HOLD);
      ce_d   = '0;
      if (strobe) ce_d[2*int'(way_d) +: 2] = 2'b11;
   end

   nphy_toggle_rb_waiter #(
      .WBWaitCycles    (WBWaitCycles),
      .RBTimeoutCycles (RBTimeoutCycles)
   ) u_rb_waiter (
      .clk        (iSystemClock),
      .reset      (iReset),
      .start      (rb_start),
      .ready_busy (iReadyBusy[way_q]),
      .done       (rb_done),
      .timeout    (rb_timeout)
   );

   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         state                  <= ST_IDLE;
         cnt                    <= '0;
         idx                    <= '0;
         req_q                  <= '0;
         way_q                  <= '0;
         oReqReady              <= 1'b1;
         oDone                  <= 1'b0;
         oTimeout               <= 1'b0;
         oDQOutEnable           <= 1'b0;
         oPO_DQ                 <= '0;
         oPO_ChipEnable         <= '0;
         oPO_WriteEnable        <= PH_OFF;
         oPO_AddressLatchEnable <= PH_OFF;
         oPO_CommandLatchEnable <= PH_OFF;
      end else begin
         state <= nxt;
         cnt   <= nxt_cnt;
         idx   <= nxt_idx;
         if (accept) begin
            req_q <= req_in;
            way_q <= iReqWay;
         end
         oReqReady      <= (nxt == ST_IDLE);
         oDone          <= (nxt == ST_DONE);
         oTimeout       <= (state == ST_WB_WAIT) && rb_timeout;
         oDQOutEnable   <= strobe;
         oPO_DQ         <= strobe ? {4{sel.data}} : '0;
         oPO_ChipEnable <= ce_d;
         oPO_WriteEnable <= (nxt == ST_WE_ON) ? PH_ON : PH_OFF;
         oPO_CommandLatchEnable <=
            (strobe && sel.is_cmd) ? PH_ON : PH_OFF;
         oPO_AddressLatchEnable <=
            (strobe && !sel.is_cmd) ? PH_ON : PH_OFF;
      end
   end

endmodule

// File: tb/tb_nphy_toggle_cmd_sequencer.sv
// Bench for the Toggle NAND command sequencer: vector table, random
// requests against a per-cycle trace model, and reset/back-to-back cases.
module tb_nphy_toggle_cmd_sequencer;

   localparam int NW = 4;
   localparam int SU = 1;
   localparam int WP = 2;
   localparam int HO = 1;
   localparam int WB = 10;
   localparam int TO = 100;
   localparam int NEVER = 1000000;

   logic        iSystemClock = 1'b0;
   logic        iReset;
   logic        iReqValid;
   logic        oReqReady;
   logic [1:0]  iReqWay;
   logic [7:0]  iReqCmd0;
   logic [2:0]  iReqAddrCount;
   logic [39:0] iReqAddr;
   logic        iReqHasCmd1;
   logic [7:0]  iReqCmd1;
   logic        iReqWaitRB;
   logic [3:0]  iReadyBusy;
   logic        oDone;
   logic        oTimeout;
   logic        oDQOutEnable;
   logic [31:0] oPO_DQ;
   logic [7:0]  oPO_ChipEnable;
   logic [3:0]  oPO_WriteEnable;
   logic [3:0]  oPO_AddressLatchEnable;
   logic [3:0]  oPO_CommandLatchEnable;
   logic [3:0]  oPO_ReadEnable;

   always #5 iSystemClock = ~iSystemClock;

   nphy_toggle_cmd_sequencer #(
      .NumberOfWays    (NW),
      .SetupCycles     (SU),
      .WEPulseCycles   (WP),
      .HoldCycles      (HO),
      .WBWaitCycles    (WB),
      .RBTimeoutCycles (TO)
   ) dut (
      .iSystemClock           (iSystemClock),
      .iReset                 (iReset),
      .iReqValid              (iReqValid),
      .oReqReady              (oReqReady),
      .iReqWay                (iReqWay),
      .iReqCmd0               (iReqCmd0),
      .iReqAddrCount          (iReqAddrCount),
      .iReqAddr               (iReqAddr),
      .iReqHasCmd1            (iReqHasCmd1),
      .iReqCmd1               (iReqCmd1),
      .iReqWaitRB             (iReqWaitRB),
      .iReadyBusy             (iReadyBusy),
      .oDone                  (oDone),
      .oTimeout               (oTimeout),
      .oDQOutEnable           (oDQOutEnable),
      .oPO_DQ                 (oPO_DQ),
      .oPO_ChipEnable         (oPO_ChipEnable),
      .oPO_WriteEnable        (oPO_WriteEnable),
      .oPO_AddressLatchEnable (oPO_AddressLatchEnable),
      .oPO_CommandLatchEnable (oPO_CommandLatchEnable),
      .oPO_ReadEnable         (oPO_ReadEnable)
   );

   typedef struct packed {
      logic        ready;
      logic        done;
      logic        timeout;
      logic        oe;
      logic [7:0]  ce;
      logic [3:0]  cle;
      logic [3:0]  ale;
      logic [3:0]  we;
      logic [3:0]  re;
      logic [31:0] dq;
   } obs_t;

   typedef struct {
      logic [1:0]  way;
      logic [7:0]  cmd0;
      logic [2:0]  n;
      logic [39:0] addr;
      logic        has1;
      logic [7:0]  cmd1;
      logic        wait_rb;
      int          rb_delay;
      int          done_cyc;
      logic        to;
   } vec_t;

   int   passed = 0;
   int   total  = 0;
   obs_t exp_q[$];
   obs_t rst_obs;
   vec_t tbl[6];

   function automatic obs_t observe();
      obs_t o;
      o.ready   = oReqReady;
      o.done    = oDone;
      o.timeout = oTimeout;
      o.oe      = oDQOutEnable;
      o.ce      = oPO_ChipEnable;
      o.cle     = oPO_CommandLatchEnable;
      o.ale     = oPO_AddressLatchEnable;
      o.we      = oPO_WriteEnable;
      o.re      = oPO_ReadEnable;
      o.dq      = oPO_DQ;
      return o;
   endfunction

   task automatic check(string name, int cyc, obs_t got, obs_t want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s cycle %0d: got %h want %h",
                    name, cyc, got, want);
   endtask

   task automatic check_int(string name, int got, int want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s: got %0d want %0d", name, got, want);
   endtask

   function automatic vec_t mk(int way, int cmd0, int n,
                               logic [39:0] addr, bit h1, int cmd1,
                               bit w, int rbd, int dc, bit to);
      vec_t v;
      v.way = 2'(way);   v.cmd0 = 8'(cmd0); v.n = 3'(n);
      v.addr = addr;     v.has1 = h1;       v.cmd1 = 8'(cmd1);
      v.wait_rb = w;     v.rb_delay = rbd;  v.done_cyc = dc;
      v.to = to;
      return v;
   endfunction

   // Expected trace, one record per cycle after acceptance; record i
   // is cycle i+1. R/B reads ready from cycle rb_delay onward.
   function automatic void build(vec_t v);
      obs_t        r;
      logic [7:0]  bl[$];
      bit          kl[$];
      int          na;
      logic        to;
      exp_q.delete();
      na = (v.n > 3'd5) ? 5 : int'(v.n);
      bl.push_back(v.cmd0);
      kl.push_back(1'b1);
      for (int i = 0; i < na; i++) begin
         bl.push_back(v.addr[8*i +: 8]);
         kl.push_back(1'b0);
      end
      if (v.has1) begin
         bl.push_back(v.cmd1);
         kl.push_back(1'b1);
      end
      foreach (bl[b]) begin
         for (int c = 0; c < SU + WP + HO; c++) begin
            r     = '0;
            r.oe  = 1'b1;
            r.ce  = 8'b0000_0011 << (2 * int'(v.way));
            r.cle = kl[b] ? 4'hF : 4'h0;
            r.ale = kl[b] ? 4'h0 : 4'hF;
            r.we  = (c >= SU && c < SU + WP) ? 4'hF : 4'h0;
            r.dq  = {4{bl[b]}};
            exp_q.push_back(r);
         end
      end
      to = 1'b0;
      if (v.wait_rb) begin
         for (int c = 0; c < WB; c++) exp_q.push_back('0);
         to = 1'b1;
         for (int p = 0; p < TO; p++) begin
            exp_q.push_back('0);
            if (exp_q.size() >= v.rb_delay) begin
               to = 1'b0;
               break;
            end
         end
      end
      r = '0;
      r.done = 1'b1;
      r.timeout = to;
      exp_q.push_back(r);
      r = '0;
      r.ready = 1'b1;
      exp_q.push_back(r);
   endfunction

   task automatic drive_req(vec_t v);
      iReqValid     = 1'b1;
      iReqWay       = v.way;
      iReqCmd0      = v.cmd0;
      iReqAddrCount = v.n;
      iReqAddr      = v.addr;
      iReqHasCmd1   = v.has1;
      iReqCmd1      = v.cmd1;
      iReqWaitRB    = v.wait_rb;
   endtask

   // Entered and left #1 after an edge in a cycle where the DUT is idle.
   task automatic run(vec_t v, bit keep, string tag);
      int   done_at;
      logic to_seen;
      obs_t got;
      build(v);
      drive_req(v);
      @(posedge iSystemClock); #1;
      done_at = -1;
      to_seen = 1'b0;
      for (int c = 1; c <= exp_q.size(); c++) begin
         iReadyBusy = (c >= v.rb_delay) ? 4'(1 << v.way)
                                        : ~4'(1 << v.way);
         if (keep) begin
            iReqWay  = 2'($urandom);
            iReqCmd0 = 8'($urandom);
            iReqAddr = {8'($urandom), 32'($urandom)};
         end else begin
            iReqValid = 1'b0;
         end
         got = observe();
         check(tag, c, got, exp_q[c-1]);
         if (got.done && done_at < 0) begin
            done_at = c;
            to_seen = got.timeout;
         end
         if (c < exp_q.size()) begin
            @(posedge iSystemClock); #1;
         end
      end
      if (v.done_cyc > 0) begin
         check_int({tag, "_done_cycle"}, done_at, v.done_cyc);
         check_int({tag, "_timeout"}, int'(to_seen), int'(v.to));
      end
   endtask

   initial begin
      vec_t v;
      obs_t got;
      tbl[0] = mk(2, 'hFF, 0, 40'h0, 0, 0, 0, NEVER, 5, 0);
      tbl[1] = mk(1, 'h00, 5, 40'h0403020100, 1, 'h30, 1, 50, 51, 0);
      tbl[2] = mk(1, 'h00, 5, 40'h0403020100, 1, 'h30, 1, NEVER, 139, 1);
      tbl[3] = mk(0, 'hA5, 7, 40'h5544332211, 0, 0, 0, NEVER, 25, 0);
      tbl[4] = mk(3, 'h60, 2, 40'h000000BEEF, 1, 'hD0, 1, 1, 28, 0);
      tbl[5] = mk(2, 'h80, 1, 40'h000000007F, 1, 'h10, 0, NEVER, 13, 0);
      rst_obs = '0;
      rst_obs.ready = 1'b1;

      iReset = 1'b1;
      iReqValid = 1'b0;
      iReqWay = '0; iReqCmd0 = '0; iReqAddrCount = '0;
      iReqAddr = '0; iReqHasCmd1 = 1'b0; iReqCmd1 = '0;
      iReqWaitRB = 1'b0; iReadyBusy = '0;
      repeat (3) @(posedge iSystemClock);
      #1;
      check("reset_state", 0, observe(), rst_obs);
      iReset = 1'b0;
      @(posedge iSystemClock); #1;
      check("idle_after_reset", 0, observe(), rst_obs);

      for (int i = 0; i < 6; i++) run(tbl[i], 1'b0, $sformatf("tbl%0d", i));

      // Valid held high across two requests.
      run(tbl[0], 1'b1, "b2b_first");
      run(tbl[4], 1'b0, "b2b_second");

      // Reset during the third byte's WE_ON (cycle 10).
      v = tbl[1];
      build(v);
      drive_req(v);
      @(posedge iSystemClock); #1;
      iReqValid = 1'b0;
      iReadyBusy = '0;
      for (int c = 2; c <= 10; c++) begin
         @(posedge iSystemClock); #1;
      end
      check("pre_reset_we_on", 10, observe(), exp_q[9]);
      iReset = 1'b1;
      @(posedge iSystemClock); #1;
      check("reset_abort", 0, observe(), rst_obs);
      iReset = 1'b0;
      iReadyBusy = '1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge iSystemClock); #1;
         got = observe();
         check("post_abort_idle", c, got, rst_obs);
      end

      for (int i = 0; i < 24; i++) begin
         v.way      = 2'($urandom);
         v.cmd0     = 8'($urandom);
         v.n        = 3'($urandom);
         v.addr     = {8'($urandom), 32'($urandom)};
         v.has1     = 1'($urandom);
         v.cmd1     = 8'($urandom);
         v.wait_rb  = 1'($urandom);
         v.rb_delay = ($urandom_range(0, 3) == 0)
                      ? NEVER : int'($urandom_range(1, 160));
         v.done_cyc = 0;
         v.to       = 1'b0;
         run(v, (i < 23) && ($urandom_range(0, 1) == 1),
             $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
